// File: rtl/mux_scan_reg.sv
// Registered CHANNELS-to-1 multiplexer with manual select and round-robin masked scan.
// Captured samples are delivered over a valid/ready handshake with one-sample buffering.
module mux_scan_reg #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 8,
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [CHANNELS*WIDTH-1:0] i_data_in,
  input  logic [SEL_W-1:0]          i_select,
  input  logic                      i_mode,
  input  logic [CHANNELS-1:0]       i_ch_mask,
  input  logic                      i_en,
  input  logic                      i_ready,
  output logic [WIDTH-1:0]          o_data_out,
  output logic [SEL_W-1:0]          o_ch_out,
  output logic                      o_sel_err,
  output logic                      o_valid,
  output logic [0:0]                o_state
);

  // Handshake: a sample is transferred on a rising edge where o_valid and i_ready are both 1;
  // while o_valid=1 and i_ready=0 every output holds, and i_ready only acts at the clock edge.

  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_PRESENT = 1'b1;

  logic [0:0]       r_state;
  logic [SEL_W-1:0] r_ptr;
  logic [WIDTH-1:0] r_data;
  logic [SEL_W-1:0] r_ch;
  logic             r_err;

  logic             w_scan_found;
  logic [SEL_W-1:0] w_scan_ch;
  logic [SEL_W-1:0] w_ptr_next;
  logic [SEL_W-1:0] w_cap_ch;
  logic [WIDTH-1:0] w_cap_data;
  logic             w_cap_err;
  logic             w_eligible;
  logic             w_take;

  // First mask bit at or above r_ptr, wrapping; the extra index bit keeps ptr+i from overflowing.
  always_comb begin : scan_search
    logic [SEL_W:0] v_idx;
    w_scan_found = 1'b0;
    w_scan_ch    = '0;
    v_idx        = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      v_idx = {1'b0, r_ptr} + (SEL_W+1)'(i);
      if (v_idx >= (SEL_W+1)'(CHANNELS)) v_idx = v_idx - (SEL_W+1)'(CHANNELS);
      if (!w_scan_found && i_ch_mask[v_idx[SEL_W-1:0]]) begin
        w_scan_found = 1'b1;
        w_scan_ch    = v_idx[SEL_W-1:0];
      end
    end
  end

  assign w_ptr_next = (w_scan_ch == SEL_W'(CHANNELS - 1)) ? '0 : w_scan_ch + 1'b1;

  // An out-of-range select matches no slice, so the data falls back to zero.
  always_comb begin
    w_cap_ch   = i_mode ? w_scan_ch : i_select;
    w_cap_err  = !i_mode && ({1'b0, i_select} >= (SEL_W+1)'(CHANNELS));
    w_cap_data = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (w_cap_ch == SEL_W'(c)) w_cap_data = i_data_in[c*WIDTH +: WIDTH];
    end
  end

  assign w_eligible = i_en && (!i_mode || w_scan_found);
  assign w_take     = (r_state == S_IDLE) || i_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_data  <= '0;
      r_ch    <= '0;
      r_err   <= 1'b0;
    end else if (w_take) begin
      if (w_eligible) begin
        r_state <= S_PRESENT;
        r_data  <= w_cap_data;
        r_ch    <= w_cap_ch;
        r_err   <= w_cap_err;
        if (i_mode) r_ptr <= w_ptr_next;
      end else begin
        r_state <= S_IDLE;
      end
    end
  end

  assign o_data_out = r_data;
  assign o_ch_out   = r_ch;
  assign o_sel_err  = r_err;
  assign o_valid    = (r_state == S_PRESENT);
  assign o_state    = r_state;

endmodule

// File: tb/tb_mux_scan_reg.sv
// Bench for mux_scan_reg: an 8-channel instance checked every cycle against a sample-level model,
// plus a 6-channel instance for out-of-range select; directed vectors with literal expectations.
module tb_mux_scan_reg;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- 8-channel DUT ----------------
  logic [63:0] data_in;
  logic [2:0]  sel;
  logic        mode, en, ready;
  logic [7:0]  mask;
  logic [7:0]  data_out;
  logic [2:0]  ch_out;
  logic        sel_err, valid;
  logic [0:0]  state;

  mux_scan_reg #(.WIDTH(8), .CHANNELS(8)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_data_in(data_in), .i_select(sel),
    .i_mode(mode), .i_ch_mask(mask), .i_en(en), .i_ready(ready),
    .o_data_out(data_out), .o_ch_out(ch_out), .o_sel_err(sel_err),
    .o_valid(valid), .o_state(state)
  );

  // ---------------- 6-channel DUT ----------------
  logic [47:0] data6;
  logic [2:0]  sel6;
  logic        mode6, en6, ready6;
  logic [5:0]  mask6;
  logic [7:0]  data_out6;
  logic [2:0]  ch_out6;
  logic        sel_err6, valid6;
  logic [0:0]  state6;

  mux_scan_reg #(.WIDTH(8), .CHANNELS(6)) u_dut6 (
    .i_clk(clk), .i_rst_n(rst_n), .i_data_in(data6), .i_select(sel6),
    .i_mode(mode6), .i_ch_mask(mask6), .i_en(en6), .i_ready(ready6),
    .o_data_out(data_out6), .o_ch_out(ch_out6), .o_sel_err(sel_err6),
    .o_valid(valid6), .o_state(state6)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- sample-level model (8-channel instance) ----------------
  logic       m_valid = 1'b0;
  logic [7:0] m_data  = 8'h00;
  int         m_ch    = 0;
  logic       m_err   = 1'b0;
  int         m_ptr   = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 1'b0; m_data = 8'h00; m_ch = 0; m_err = 1'b0; m_ptr = 0;
    end else if (!m_valid || ready) begin
      int pick;
      pick = -1;
      if (mode) begin
        for (int k = 0; k < 8; k++)
          if (pick < 0 && mask[(m_ptr + k) % 8]) pick = (m_ptr + k) % 8;
      end else begin
        pick = int'(sel);
      end
      if (en && pick >= 0) begin
        m_valid = 1'b1;
        m_ch    = pick;
        m_data  = data_in[pick*8 +: 8];
        m_err   = 1'b0;
        if (mode) m_ptr = (pick + 1) % 8;
      end else begin
        m_valid = 1'b0;
      end
    end
  end

  logic cmp_on = 1'b1;
  always @(negedge clk) begin
    if (cmp_on) begin
      check("model_valid", 32'(valid), 32'(m_valid));
      check("model_state", 32'(state), 32'(m_valid));
      check("model_data",  32'(data_out), 32'(m_data));
      check("model_ch",    32'(ch_out), 32'(m_ch));
      check("model_err",   32'(sel_err), 32'(m_err));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic [7:0] base);
    for (int i = 0; i < 8; i++) data_in[i*8 +: 8] = base + 8'(i);
  endtask

  int exp_seq[6] = '{0, 2, 5, 7, 0, 2};

  // ---------------- directed stimulus ----------------
  initial begin
    rst_n = 1'b0;
    sel = 3'd0; mode = 1'b0; en = 1'b0; ready = 1'b0; mask = 8'h00;
    set_data(8'hA0);
    for (int i = 0; i < 6; i++) data6[i*8 +: 8] = 8'hB0 + 8'(i);
    sel6 = 3'd0; mode6 = 1'b0; en6 = 1'b0; ready6 = 1'b1; mask6 = 6'h00;

    #12;
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_data",  32'(data_out), 32'd0);
    check("reset_ch",    32'(ch_out), 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle_no_en", 32'(valid), 32'd0);

    // manual back-to-back
    en = 1'b1; mode = 1'b0; ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      sel = 3'(k);
      tick();
      check("man_data",  32'(data_out), 32'(8'hA0 + k));
      check("man_ch",    32'(ch_out), 32'(k));
      check("man_valid", 32'(valid), 32'd1);
    end

    // out-of-range select on 6 channels
    en6 = 1'b1; sel6 = 3'd7;
    tick();
    check("oor_data",  32'(data_out6), 32'd0);
    check("oor_ch",    32'(ch_out6), 32'd7);
    check("oor_err",   32'(sel_err6), 32'd1);
    check("oor_valid", 32'(valid6), 32'd1);
    sel6 = 3'd2;
    tick();
    check("inr_data", 32'(data_out6), 32'hB2);
    check("inr_ch",   32'(ch_out6), 32'd2);
    check("inr_err",  32'(sel_err6), 32'd0);
    en6 = 1'b0;

    // backpressure hold
    sel = 3'd3;
    tick();
    check("bp_cap", 32'(ch_out), 32'd3);
    ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      sel = 3'(k + 4);
      set_data(8'h10 + 8'(k));
      tick();
      check("bp_data",  32'(data_out), 32'hA3);
      check("bp_ch",    32'(ch_out), 32'd3);
      check("bp_valid", 32'(valid), 32'd1);
    end
    set_data(8'hA0);
    ready = 1'b1; sel = 3'd6;
    tick();
    check("bp_next_ch",   32'(ch_out), 32'd6);
    check("bp_next_data", 32'(data_out), 32'hA6);

    // scan with wrap
    mode = 1'b1; mask = 8'b1010_0101;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("scan_ch",   32'(ch_out), 32'(exp_seq[k]));
      check("scan_data", 32'(data_out), 32'(8'hA0 + exp_seq[k]));
    end

    // empty mask
    mask = 8'h00;
    tick();
    check("empty_valid", 32'(valid), 32'd0);
    check("empty_hold",  32'(ch_out), 32'd2);
    tick(); tick();
    check("empty_stay", 32'(valid), 32'd0);

    // disable while presenting
    mask = 8'b1010_0101; ready = 1'b0;
    tick();
    check("dis_cap_ch", 32'(ch_out), 32'd5);
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("dis_hold", 32'(valid), 32'd1);
    end
    ready = 1'b1;
    tick();
    check("dis_drop",  32'(valid), 32'd0);
    check("dis_keep",  32'(ch_out), 32'd5);

    // reset mid-handshake
    en = 1'b1; ready = 1'b0;
    tick();
    check("pre_rst_ch", 32'(ch_out), 32'd7);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(valid), 32'd0);
    check("arst_data",  32'(data_out), 32'd0);
    check("arst_ch",    32'(ch_out), 32'd0);
    check("arst_err",   32'(sel_err), 32'd0);
    mask = 8'hFF; ready = 1'b1;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    tick();
    check("post_rst_ch",   32'(ch_out), 32'd0);
    check("post_rst_data", 32'(data_out), 32'hA0);
    tick();
    check("post_rst_ch1", 32'(ch_out), 32'd1);

    // pointer retained across a manual capture
    mode = 1'b0; sel = 3'd4;
    tick();
    check("mix_man_ch", 32'(ch_out), 32'd4);
    mode = 1'b1;
    tick();
    check("mix_scan_ch", 32'(ch_out), 32'd2);

    @(negedge clk);
    cmp_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
